// File: rtl/dm_ctrl_if.sv
// Request/response bus between the MEM-stage requester and the data-memory controller.
// The master drives a request and samples the response; the slave is the controller.
interface dm_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  a_lo_o;
  logic        adel_o;
  logic        ades_o;

  modport master (
    output req_i, we_i, size_i, addr_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, a_lo_o, adel_o, ades_o
  );

  modport slave (
    input  req_i, we_i, size_i, addr_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, a_lo_o, adel_o, ades_o
  );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory controller for the MEM stage: serialised loads/stores with byte enables,
// programmable wait states and AdEL/AdES fault flags. Returns raw words for the load extender.
module dm_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  dm_ctrl_if.slave bus
);

  localparam int WORDS = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  a_lo_q, a_lo_d;
  logic        adel_q, adel_d;
  logic        ades_q, ades_d;

  logic [31:0] mem [WORDS];

  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic              commit;
  logic [3:0]        be;
  logic [31:0]       wr_data;
  logic [ADDR_W-1:0] word_idx;

  always_comb begin
    misaligned   = 1'b0;
    unique case (size_q)
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (addr_q[1:0] != 2'b00);
    endcase
    out_of_range = |addr_q[31:ADDR_W+2];
    fault        = misaligned || out_of_range;
    commit       = (state_q == S_WAIT) && (cnt_q == 4'd0);
    word_idx     = addr_q[ADDR_W+1:2];
  end

  // Sub-word stores replicate the lane data so the byte enable alone picks the target bytes.
  always_comb begin
    be      = 4'b1111;
    wr_data = wdata_q;
    unique case (size_q)
      2'b01: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be      = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      a_lo_q  <= 2'b00;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      a_lo_q  <= a_lo_d;
      adel_q  <= adel_d;
      ades_q  <= ades_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.req_i) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latching, wait countdown and response capture at the commit edge.
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    a_lo_d  = a_lo_q;
    adel_d  = adel_q;
    ades_d  = ades_q;
    if (state_q == S_IDLE && bus.req_i) begin
      cnt_d   = 4'(WAIT_CYC);
      we_d    = bus.we_i;
      size_d  = bus.size_i;
      addr_d  = bus.addr_i;
      wdata_d = bus.wdata_i;
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (commit) begin
      rdata_d = (fault || we_q) ? 32'd0 : mem[word_idx];
      a_lo_d  = addr_q[1:0];
      adel_d  = fault && !we_q;
      ades_d  = fault && we_q;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && we_q && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    bus.ready_o  = (state_q == S_IDLE);
    bus.rvalid_o = (state_q == S_RESP);
    bus.rdata_o  = rdata_q;
    bus.a_lo_o   = a_lo_q;
    bus.adel_o   = adel_q;
    bus.ades_o   = ades_q;
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: a vector table of loads/stores with hand-computed results,
// plus sequences for reset behaviour, mid-access reset and back-to-back throughput.
module tb_dm_ctrl;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  dm_ctrl_if bus1 ();
  dm_ctrl_if bus_w0 ();
  dm_ctrl_if bus_w15 ();

  dm_ctrl #(.ADDR_W(10), .WAIT_CYC(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  dm_ctrl #(.ADDR_W(10), .WAIT_CYC(0)) dut_w0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_w0)
  );

  dm_ctrl #(.ADDR_W(10), .WAIT_CYC(15)) dut_w15 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_w15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_alo;
    logic        exp_adel;
    logic        exp_ades;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(string name, logic we, logic [1:0] size, logic [31:0] addr,
                                 logic [31:0] wdata, logic [31:0] exp_rdata, logic [1:0] exp_alo,
                                 logic exp_adel, logic exp_ades);
    vec_t v;
    v.name      = name;
    v.we        = we;
    v.size      = size;
    v.addr      = addr;
    v.wdata     = wdata;
    v.exp_rdata = exp_rdata;
    v.exp_alo   = exp_alo;
    v.exp_adel  = exp_adel;
    v.exp_ades  = exp_ades;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Issues one access on bus1 and returns at the negedge where rvalid_o is seen.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, output int lat);
    int guard;
    guard = 0;
    while (!bus1.ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("ready_timeout", 32'd0, 32'd1);
    bus1.we_i    = we;
    bus1.size_i  = size;
    bus1.addr_i  = addr;
    bus1.wdata_i = wdata;
    bus1.req_i   = 1'b1;
    @(negedge clk);
    bus1.req_i = 1'b0;
    lat = 1;
    while (!bus1.rvalid_o && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) checkOutput("rvalid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int prev0, prev15, n0, n15, first0, first15, pulses;

    n_checks = 0;
    n_fail   = 0;

    bus_w0.req_i    = 1'b0;
    bus_w0.we_i     = 1'b0;
    bus_w0.size_i   = 2'b00;
    bus_w0.addr_i   = 32'd0;
    bus_w0.wdata_i  = 32'd0;
    bus_w15.req_i   = 1'b0;
    bus_w15.we_i    = 1'b0;
    bus_w15.size_i  = 2'b00;
    bus_w15.addr_i  = 32'd0;
    bus_w15.wdata_i = 32'd0;

    // Reset held with a pending store request: nothing may be accepted.
    rst_n        = 1'b0;
    bus1.req_i   = 1'b1;
    bus1.we_i    = 1'b1;
    bus1.size_i  = 2'b00;
    bus1.addr_i  = 32'h0000_0044;
    bus1.wdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_ready", 32'(bus1.ready_o), 32'd1);
      checkOutput("rst_rvalid", 32'(bus1.rvalid_o), 32'd0);
    end
    checkOutput("rst_rdata", bus1.rdata_o, 32'd0);
    checkOutput("rst_a_lo", 32'(bus1.a_lo_o), 32'd0);
    checkOutput("rst_adel", 32'(bus1.adel_o), 32'd0);
    checkOutput("rst_ades", 32'(bus1.ades_o), 32'd0);
    bus1.req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_rvalid", 32'(bus1.rvalid_o), 32'd0);

    vecs.push_back(mkVec("sw_10",      1'b1, 2'b00, 32'h10,   32'h1234_5678, 32'h0,          2'd0, 1'b0, 1'b0));
    vecs.push_back(mkVec("lw_10",      1'b0, 2'b00, 32'h10,   32'h0,         32'h1234_5678,  2'd0, 1'b0, 1'b0));
    vecs.push_back(mkVec("sb_11",      1'b1, 2'b10, 32'h11,   32'h0000_00AB, 32'h0,          2'd1, 1'b0, 1'b0));
    vecs.push_back(mkVec("sh_12",      1'b1, 2'b01, 32'h12,   32'h0000_CDEF, 32'h0,          2'd2, 1'b0, 1'b0));
    vecs.push_back(mkVec("lw_10_mix",  1'b0, 2'b00, 32'h10,   32'h0,         32'hCDEF_AB78,  2'd0, 1'b0, 1'b0));
    vecs.push_back(mkVec("lb_13",      1'b0, 2'b10, 32'h13,   32'h0,         32'hCDEF_AB78,  2'd3, 1'b0, 1'b0));
    vecs.push_back(mkVec("sw_20",      1'b1, 2'b00, 32'h20,   32'h5566_7788, 32'h0,          2'd0, 1'b0, 1'b0));
    vecs.push_back(mkVec("lh_21_mis",  1'b0, 2'b01, 32'h21,   32'h0,         32'h0,          2'd1, 1'b1, 1'b0));
    vecs.push_back(mkVec("lw_20_a",    1'b0, 2'b00, 32'h20,   32'h0,         32'h5566_7788,  2'd0, 1'b0, 1'b0));
    vecs.push_back(mkVec("sw_22_mis",  1'b1, 2'b00, 32'h22,   32'hDEAD_BEEF, 32'h0,          2'd2, 1'b0, 1'b1));
    vecs.push_back(mkVec("lw_20_b",    1'b0, 2'b00, 32'h20,   32'h0,         32'h5566_7788,  2'd0, 1'b0, 1'b0));
    vecs.push_back(mkVec("lw_oor",     1'b0, 2'b00, 32'h1000, 32'h0,         32'h0,          2'd0, 1'b1, 1'b0));
    vecs.push_back(mkVec("sb_oor",     1'b1, 2'b10, 32'h8000_0001, 32'h99,   32'h0,          2'd1, 1'b0, 1'b1));
    vecs.push_back(mkVec("lh_22",      1'b0, 2'b01, 32'h22,   32'h0,         32'h5566_7788,  2'd2, 1'b0, 1'b0));
    vecs.push_back(mkVec("sw11_28",    1'b1, 2'b11, 32'h28,   32'hA5A5_A5A5, 32'h0,          2'd0, 1'b0, 1'b0));
    vecs.push_back(mkVec("sb_2a",      1'b1, 2'b10, 32'h2A,   32'hFFFF_FF3C, 32'h0,          2'd2, 1'b0, 1'b0));
    vecs.push_back(mkVec("lw11_28",    1'b0, 2'b11, 32'h28,   32'h0,         32'hA53C_A5A5,  2'd0, 1'b0, 1'b0));
    vecs.push_back(mkVec("sh_2e_hi",   1'b1, 2'b01, 32'h2E,   32'hFFFF_1234, 32'h0,          2'd2, 1'b0, 1'b0));
    vecs.push_back(mkVec("lw_2c_nx",   1'b0, 2'b00, 32'h2C,   32'h0,         32'h0,          2'd0, 1'b0, 1'b0));

    // The last vector reads a word whose low half was never written, so seed it first.
    vecs[18] = mkVec("sh_2c_lo",   1'b1, 2'b01, 32'h2C,   32'h0000_5678, 32'h0,          2'd0, 1'b0, 1'b0);
    vecs.push_back(mkVec("lw_2c",      1'b0, 2'b00, 32'h2C,   32'h0,         32'h1234_5678,  2'd0, 1'b0, 1'b0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat);
      checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'd3);
      checkOutput({vecs[i].name, "_rdata"}, bus1.rdata_o, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_a_lo"}, 32'(bus1.a_lo_o), 32'(vecs[i].exp_alo));
      checkOutput({vecs[i].name, "_adel"}, 32'(bus1.adel_o), 32'(vecs[i].exp_adel));
      checkOutput({vecs[i].name, "_ades"}, 32'(bus1.ades_o), 32'(vecs[i].exp_ades));
      @(negedge clk);
      checkOutput({vecs[i].name, "_pulse_end"}, 32'(bus1.rvalid_o), 32'd0);
      checkOutput({vecs[i].name, "_hold"}, bus1.rdata_o, vecs[i].exp_rdata);
    end

    // Reset during the wait state of a store must abort it without a write or a pulse.
    applyStimulus(1'b1, 2'b00, 32'h30, 32'h0, lat);
    @(negedge clk);
    bus1.we_i    = 1'b1;
    bus1.size_i  = 2'b00;
    bus1.addr_i  = 32'h30;
    bus1.wdata_i = 32'hFFFF_FFFF;
    bus1.req_i   = 1'b1;
    @(negedge clk);
    bus1.req_i = 1'b0;
    checkOutput("abort_in_wait", 32'(bus1.ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(bus1.ready_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus1.rvalid_o) pulses++;
    end
    checkOutput("abort_no_pulse", 32'(pulses), 32'd0);
    applyStimulus(1'b0, 2'b00, 32'h30, 32'h0, lat);
    checkOutput("abort_lw_30", bus1.rdata_o, 32'd0);
    checkOutput("abort_lw_adel", 32'(bus1.adel_o), 32'd0);
    @(negedge clk);

    // Continuous requests: one pulse every WAIT_CYC+3 cycles.
    bus_w0.we_i     = 1'b1;
    bus_w0.wdata_i  = 32'h1;
    bus_w0.req_i    = 1'b1;
    bus_w15.we_i    = 1'b1;
    bus_w15.wdata_i = 32'h2;
    bus_w15.req_i   = 1'b1;
    prev0   = -1;
    prev15  = -1;
    n0      = 0;
    n15     = 0;
    first0  = -1;
    first15 = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (bus_w0.rvalid_o) begin
        if (prev0 >= 0) checkOutput("w0_period", 32'(cyc - prev0), 32'd3);
        else first0 = cyc;
        prev0 = cyc;
        n0++;
      end
      if (bus_w15.rvalid_o) begin
        if (prev15 >= 0) checkOutput("w15_period", 32'(cyc - prev15), 32'd18);
        else first15 = cyc;
        prev15 = cyc;
        n15++;
      end
    end
    bus_w0.req_i  = 1'b0;
    bus_w15.req_i = 1'b0;
    checkOutput("w0_first", 32'(first0), 32'd2);
    checkOutput("w15_first", 32'(first15), 32'd17);
    checkOutput("w0_count", 32'(n0), 32'd33);
    checkOutput("w15_count", 32'(n15), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
